noc_link_stage: RTL and testbench



---
 rtl/noc_link_stage.sv | 152 +++++++++++++++
 tb/tb_noc_link_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_stage.sv
// Elastic credit-handshaked buffer for one mesh link, with Hermes packet tracking on
// departing flits and saturating per-link traffic statistics.
module noc_link_stage #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic                  clock_tx,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic                  in_packet
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullOcc = DEPTH[PtrW:0];

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   occ_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    StHdr,
    StSize,
    StPayload
  } state_e;

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  occ_t   occ_q, occ_d;
  logic   rdy_q;
  state_e state_q, state_d;
  logic [FLIT_WIDTH-1:0] rem_q, rem_d;
  logic   in_packet_q, in_packet_d;
  cnt_t   pkt_cnt_q, pkt_cnt_d;
  cnt_t   flit_cnt_q, flit_cnt_d;
  cnt_t   stall_cnt_q, stall_cnt_d;
  logic   push, pop, pkt_done;

  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    return (en && (v != '1)) ? v + cnt_t'(1) : v;
  endfunction

  // rdy_q keeps credit low through reset and rises on the first edge after release.
  assign credit_o = rdy_q && (occ_q < FullOcc);
  assign tx       = (occ_q != '0);
  assign data_o   = tx ? mem_q[rd_ptr_q] : '0;
  assign clock_tx = clock;

  assign push = rx && credit_o;
  assign pop  = tx && credit_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pkt_done = 1'b0;
    if (pop) begin
      unique case (state_q)
        StHdr: state_d = StSize;
        StSize: begin
          rem_d = data_o;
          if (data_o == '0) begin
            pkt_done = 1'b1;
            state_d  = StHdr;
          end else begin
            state_d = StPayload;
          end
        end
        StPayload: begin
          rem_d = rem_q - FLIT_WIDTH'(1);
          if (rem_q == FLIT_WIDTH'(1)) begin
            pkt_done = 1'b1;
            state_d  = StHdr;
          end
        end
        default: state_d = StHdr;
      endcase
    end
    in_packet_d = (state_d != StHdr);
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    pkt_cnt_d   = '0;
    flit_cnt_d  = '0;
    stall_cnt_d = '0;
    if (!clear_stats) begin
      pkt_cnt_d   = sat_inc(pkt_cnt_q, pkt_done);
      flit_cnt_d  = sat_inc(flit_cnt_q, pop);
      stall_cnt_d = sat_inc(stall_cnt_q, tx && !credit_i);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rdy_q       <= 1'b0;
      state_q     <= StHdr;
      rem_q       <= '0;
      in_packet_q <= 1'b0;
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rdy_q       <= 1'b1;
      state_q     <= state_d;
      rem_q       <= rem_d;
      in_packet_q <= in_packet_d;
      pkt_cnt_q   <= pkt_cnt_d;
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_count   = pkt_cnt_q;
  assign flit_count  = flit_cnt_q;
  assign stall_count = stall_cnt_q;
  assign in_packet   = in_packet_q;

endmodule

// File: tb/tb_noc_link_stage.sv
// Directed bench for noc_link_stage: a scoreboard queue tracks accepted flits and a
// negedge monitor checks every departing flit; counters and handshakes are checked inline.
module tb_noc_link_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, rx, credit_o, tx, credit_i, clock_tx, clear_stats, in_packet;
  logic [15:0] data_i, data_o;
  logic [31:0] pkt_count, flit_count, stall_count;

  logic        s_rx, s_credit_o, s_tx, s_credit_i, s_clock_tx, s_clear, s_in_packet;
  logic [15:0] s_data_i, s_data_o;
  logic [2:0]  s_pkt, s_flit, s_stall;

  noc_link_stage #(.FLIT_WIDTH(16), .DEPTH(4), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i), .clock_tx(clock_tx),
    .clear_stats(clear_stats), .pkt_count(pkt_count), .flit_count(flit_count),
    .stall_count(stall_count), .in_packet(in_packet)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  noc_link_stage #(.FLIT_WIDTH(16), .DEPTH(2), .CNT_WIDTH(3)) u_sat (
    .clock(clock), .reset(reset), .rx(s_rx), .data_i(s_data_i), .credit_o(s_credit_o),
    .tx(s_tx), .data_o(s_data_o), .credit_i(s_credit_i), .clock_tx(s_clock_tx),
    .clear_stats(s_clear), .pkt_count(s_pkt), .flit_count(s_flit),
    .stall_count(s_stall), .in_packet(s_in_packet)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] seq_d [8];
  logic        seq_p [9];

  always @(negedge clock) begin
    if (reset && rx && credit_o) sb.push_back(data_i);
  end

  always @(negedge clock) begin
    logic [15:0] exp_flit;
    if (reset && tx && credit_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL flit_out: got %h, no flit expected", data_o);
      end else begin
        exp_flit = sb.pop_front();
        if (data_o !== exp_flit) begin
          n_err++;
          $display("FAIL flit_out: got %h, expected %h", data_o, exp_flit);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  // Streams seq_d[0..n-1] back to back with credit_i=1, one extra edge to drain the last.
  task automatic run_seq(input int n);
    credit_i = 1'b1;
    for (int i = 0; i <= n; i++) begin
      rx     = (i < n);
      data_i = (i < n) ? seq_d[i] : 16'h0;
      cyc();
      if (i == 0) chk("tx_latency", {31'b0, tx}, 32'd1);
      chk($sformatf("in_packet[%0d]", i), {31'b0, in_packet}, {31'b0, seq_p[i]});
    end
    rx = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int guard;
    logic acc;
    logic exp_cr [6];

    reset = 1'b0; rx = 1'b0; data_i = '0; credit_i = 1'b0; clear_stats = 1'b0;
    s_rx = 1'b0; s_data_i = '0; s_credit_i = 1'b0; s_clear = 1'b0;
    repeat (2) cyc();
    chk("rst_tx", {31'b0, tx}, 32'd0);
    chk("rst_credit", {31'b0, credit_o}, 32'd0);
    chk("rst_data", {16'b0, data_o}, 32'd0);
    chk("rst_pkt", pkt_count, 32'd0);
    chk("rst_flit", flit_count, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_in_packet", {31'b0, in_packet}, 32'd0);
    reset = 1'b1;
    cyc();
    chk("credit_after_rst", {31'b0, credit_o}, 32'd1);

    // Basic packet: header, size 2, two payloads.
    seq_d[0] = 16'h0011; seq_d[1] = 16'h0002; seq_d[2] = 16'hAAAA; seq_d[3] = 16'hBBBB;
    seq_p[0] = 0; seq_p[1] = 1; seq_p[2] = 1; seq_p[3] = 1; seq_p[4] = 0;
    run_seq(4);
    chk("t1_flit", flit_count, 32'd4);
    chk("t1_pkt", pkt_count, 32'd1);

    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    chk("clr_flit", flit_count, 32'd0);
    chk("clr_pkt", pkt_count, 32'd0);

    // Backpressure: six offered flits, only four accepted.
    exp_cr[0] = 1; exp_cr[1] = 1; exp_cr[2] = 1; exp_cr[3] = 0; exp_cr[4] = 0; exp_cr[5] = 0;
    credit_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx = 1'b1;
      data_i = 16'(i);
      cyc();
      chk($sformatf("bp_credit[%0d]", i), {31'b0, credit_o}, {31'b0, exp_cr[i]});
    end
    chk("bp_stall", stall_count, 32'd5);
    rx = 1'b0;
    credit_i = 1'b1;
    cyc();
    chk("bp_credit_back", {31'b0, credit_o}, 32'd1);
    repeat (3) cyc();
    chk("bp_drained", {31'b0, tx}, 32'd0);
    chk("bp_flit", flit_count, 32'd4);

    // Full FIFO then streaming across pointer wrap.
    credit_i = 1'b0;
    for (k = 0; k < 4; k++) begin
      rx = 1'b1;
      data_i = 16'(100 + k);
      cyc();
    end
    credit_i = 1'b1;
    data_i = 16'(100 + k);
    chk("full_credit", {31'b0, credit_o}, 32'd0);
    cyc();
    chk("full_pop_credit", {31'b0, credit_o}, 32'd1);
    guard = 0;
    while (k < 20 && guard < 100) begin
      data_i = 16'(100 + k);
      acc = credit_o;
      cyc();
      if (acc) k++;
      guard++;
      chk("stream_credit", {31'b0, credit_o}, 32'd1);
    end
    chk("stream_count", k, 32'd20);
    rx = 1'b0;
    repeat (4) cyc();
    chk("stream_drained", {31'b0, tx}, 32'd0);

    // Zero-size packet followed by a one-payload packet.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    seq_d[0] = 16'h0055; seq_d[1] = 16'h0000; seq_d[2] = 16'h0066;
    seq_d[3] = 16'h0001; seq_d[4] = 16'h0077;
    seq_p[0] = 0; seq_p[1] = 1; seq_p[2] = 0; seq_p[3] = 1; seq_p[4] = 1; seq_p[5] = 0;
    run_seq(5);
    chk("t4_pkt", pkt_count, 32'd2);
    chk("t4_flit", flit_count, 32'd5);

    // Reset mid-packet with flits still buffered.
    seq_d[0] = 16'h0001; seq_d[1] = 16'h0005; seq_d[2] = 16'hC001; seq_d[3] = 16'hC002;
    seq_p[0] = 0; seq_p[1] = 1; seq_p[2] = 1; seq_p[3] = 1; seq_p[4] = 1;
    run_seq(4);
    credit_i = 1'b0;
    rx = 1'b1;
    data_i = 16'hD003;
    cyc();
    data_i = 16'hD004;
    cyc();
    rx = 1'b0;
    reset = 1'b0;
    cyc();
    chk("mid_rst_tx", {31'b0, tx}, 32'd0);
    chk("mid_rst_credit", {31'b0, credit_o}, 32'd0);
    chk("mid_rst_pkt", pkt_count, 32'd0);
    chk("mid_rst_flit", flit_count, 32'd0);
    chk("mid_rst_stall", stall_count, 32'd0);
    chk("mid_rst_in_packet", {31'b0, in_packet}, 32'd0);
    sb.delete();
    reset = 1'b1;
    cyc();
    chk("mid_rst_credit_back", {31'b0, credit_o}, 32'd1);
    seq_d[0] = 16'h0002; seq_d[1] = 16'h0001; seq_d[2] = 16'h0E0E;
    seq_p[0] = 0; seq_p[1] = 1; seq_p[2] = 1; seq_p[3] = 0;
    run_seq(3);
    chk("fresh_pkt", pkt_count, 32'd1);
    chk("fresh_flit", flit_count, 32'd3);

    // Clear during a pop: the pop's increment is lost, parser still advances.
    credit_i = 1'b1;
    rx = 1'b1;
    data_i = 16'h1234;
    cyc();
    rx = 1'b0;
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    chk("clr_pop_flit", flit_count, 32'd0);
    chk("clr_pop_in_packet", {31'b0, in_packet}, 32'd1);
    chk("clr_pop_tx", {31'b0, tx}, 32'd0);

    // Stall counter saturation on the 3-bit instance.
    s_rx = 1'b1;
    s_data_i = 16'h00AB;
    cyc();
    s_rx = 1'b0;
    repeat (12) cyc();
    chk("sat_stall", {29'b0, s_stall}, 32'd7);
    chk("sat_tx", {31'b0, s_tx}, 32'd1);
    s_clear = 1'b1;
    cyc();
    s_clear = 1'b0;
    chk("sat_clear", {29'b0, s_stall}, 32'd0);
    cyc();
    chk("sat_recount", {29'b0, s_stall}, 32'd1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
